mnist_input_packer: RTL and testbench

Upstream feeder for the RBM core. Accepts a raster stream of 8-bit grayscale pixels and binarizes each one. Packs the resulting bits into the flat visible-layer vector the core reads on its input port, then raises `data_valid` and holds the image stable until the core reports `finish`. The block then re-arms for the next image.

---
 rtl/mnist_input_packer_pkg.sv | 26 ++
 rtl/mnist_input_packer_binarizer.sv | 48 ++++
 rtl/mnist_input_packer.sv | 102 ++++++++++
 tb/tb_mnist_input_packer.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/mnist_input_packer_pkg.sv
// mnist_input_packer_pkg
// Shared definitions for the MNIST input packer:
//   - FSM state encoding (ST_FILL / ST_HOLD)
//   - dither LFSR tap mask and one-step advance helper
//   - default visible-layer size. Defining SPARSE selects the 64-unit build.
package mnist_input_packer_pkg;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  // Galois form of x^16+x^14+x^13+x^11+1, shifting right
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

`ifdef SPARSE
  localparam int unsigned DEFAULT_INPUT_DIM = 64;
`else
  localparam int unsigned DEFAULT_INPUT_DIM = 784;
`endif

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/mnist_input_packer_binarizer.sv
// pixel_binarizer
// Turns one pixel into one visible-unit bit.
//   Default build: bin = (pixel >= THRESHOLD), purely combinational.
//   INPUT_DITHER_EN defined: bin = (pixel > lfsr[7:0]) using a 16-bit Galois
//   LFSR that steps once per 'advance' strobe (one per accepted pixel).
// Ports:
//   clock, reset   - rising-edge clock, synchronous active-high reset
//   pixel          - unsigned pixel value
//   advance        - step the LFSR after this compare (dither build only)
//   bin            - binarized bit
module pixel_binarizer
  import mnist_input_packer_pkg::*;
#(
  parameter int unsigned                PIXEL_BITS = 8,
  parameter logic [PIXEL_BITS-1:0]      THRESHOLD  = 8'd128,
  parameter logic [15:0]                LFSR_SEED  = 16'hACE1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [PIXEL_BITS-1:0] pixel,
  input  logic                  advance,
  output logic                  bin
);

`ifdef INPUT_DITHER_EN
  logic [15:0] lfsr;

  always_ff @(posedge clock) begin
    if (reset) begin
      lfsr <= LFSR_SEED;
    end else if (advance) begin
      lfsr <= lfsr_next(lfsr);
    end
  end

  // Compare uses the pre-advance value, so the first pixel sees the seed
  assign bin = pixel > PIXEL_BITS'(lfsr[7:0]);

  logic unused_cfg;
  assign unused_cfg = &{1'b0, THRESHOLD};
`else
  assign bin = pixel >= THRESHOLD;

  logic unused_cfg;
  assign unused_cfg = &{1'b0, clock, reset, advance, LFSR_SEED};
`endif

endmodule

// File: rtl/mnist_input_packer.sv
// mnist_input_packer
// Binarizes a raster pixel stream and packs it into the RBM visible vector.
// FILL accepts pixels (bit k of image_port = pixel k); after the last pixel
// the block sits in HOLD with data_valid high and image_port frozen until
// core_finish, then re-arms. A start-of-frame mid-fill realigns to index 0
// and pulses frame_err for one cycle.
// Optional: INPUT_DITHER_EN selects LFSR-dithered binarization.
// Ports:
//   clock, reset  - rising-edge clock, synchronous active-high reset
//   pixel_in/pixel_valid/pixel_sof/pixel_ready - pixel stream handshake
//   core_finish   - RBM core done with the held image
//   image_port    - packed binary image
//   data_valid    - image complete and stable (HOLD)
//   frame_err     - one-cycle pulse on frame misalignment
module mnist_input_packer
  import mnist_input_packer_pkg::*;
#(
  parameter int unsigned           INPUT_DIM  = DEFAULT_INPUT_DIM,
  parameter int unsigned           PIXEL_BITS = 8,
  parameter logic [PIXEL_BITS-1:0] THRESHOLD  = 8'd128,
  parameter logic [15:0]           LFSR_SEED  = 16'hACE1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [PIXEL_BITS-1:0] pixel_in,
  input  logic                  pixel_valid,
  input  logic                  pixel_sof,
  output logic                  pixel_ready,
  input  logic                  core_finish,
  output logic [INPUT_DIM-1:0]  image_port,
  output logic                  data_valid,
  output logic                  frame_err
);

  localparam int unsigned      CNT_W    = (INPUT_DIM > 1) ? $clog2(INPUT_DIM) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(INPUT_DIM - 1);

  state_t           state, state_next;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] idx;
  logic             accept;
  logic             last;
  logic             pix_bit;

  // Both handshake outputs decode the state register directly
  assign pixel_ready = (state == ST_FILL);
  assign data_valid  = (state == ST_HOLD);

  assign accept = pixel_valid && pixel_ready;
  assign idx    = pixel_sof ? '0 : count;
  assign last   = !pixel_sof && (count == LAST_IDX);

  pixel_binarizer #(
    .PIXEL_BITS (PIXEL_BITS),
    .THRESHOLD  (THRESHOLD),
    .LFSR_SEED  (LFSR_SEED)
  ) u_binarizer (
    .clock   (clock),
    .reset   (reset),
    .pixel   (pixel_in),
    .advance (accept),
    .bin     (pix_bit)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_FILL;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_FILL: if (accept && last) state_next = ST_HOLD;
      ST_HOLD: if (core_finish)    state_next = ST_FILL;
      default: state_next = ST_FILL;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count      <= '0;
      image_port <= '0;
      frame_err  <= 1'b0;
    end else begin
      frame_err <= accept && pixel_sof && (count != '0);
      if (accept) begin
        image_port[idx] <= pix_bit;
        if (last) begin
          count <= '0;
        end else if (pixel_sof) begin
          count <= CNT_W'(1);
        end else begin
          count <= count + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mnist_input_packer.sv
// tb_mnist_input_packer
// Randomized self-checking bench for mnist_input_packer (784-unit build).
// A frame-level reference model tracks the expected image, fill position,
// HOLD status and frame_err pulse; every cycle all outputs are compared.
module tb_mnist_input_packer;
  localparam int DIM = 784;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic [7:0]     pixel_in = '0;
  logic           pixel_valid = 1'b0;
  logic           pixel_sof = 1'b0;
  logic           pixel_ready;
  logic           core_finish = 1'b0;
  logic [DIM-1:0] image_port;
  logic           data_valid;
  logic           frame_err;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  logic [DIM-1:0] m_img;
  int             m_pos;
  bit             m_hold;
  bit             m_err;
  logic [15:0]    m_lfsr;

  logic [DIM-1:0] saved;
  logic [DIM-1:0] pattern;

  mnist_input_packer #(
    .INPUT_DIM  (DIM),
    .PIXEL_BITS (8),
    .THRESHOLD  (8'd128),
    .LFSR_SEED  (16'hACE1)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .pixel_in    (pixel_in),
    .pixel_valid (pixel_valid),
    .pixel_sof   (pixel_sof),
    .pixel_ready (pixel_ready),
    .core_finish (core_finish),
    .image_port  (image_port),
    .data_valid  (data_valid),
    .frame_err   (frame_err)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [DIM-1:0] got, input logic [DIM-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit model_bin(input logic [7:0] p);
    bit b;
`ifdef INPUT_DITHER_EN
    b = p > m_lfsr[7:0];
    m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
`else
    b = p >= 8'd128;
`endif
    return b;
  endfunction

  // Drive one cycle of inputs, update the model at the edge, check all outputs.
  task automatic cycle(input bit v, input logic [7:0] p, input bit s, input bit f, input bit r);
    int idx;
    pixel_valid = v;
    pixel_in    = p;
    pixel_sof   = s;
    core_finish = f;
    reset       = r;
    @(posedge clock);
    if (r) begin
      m_img = '0; m_pos = 0; m_hold = 0; m_err = 0; m_lfsr = 16'hACE1;
    end else if (!m_hold) begin
      m_err = 0;
      if (v) begin
        idx = s ? 0 : m_pos;
        m_img[idx] = model_bin(p);
        m_err = s && (m_pos != 0);
        if (!s && m_pos == DIM - 1) begin
          m_hold = 1;
          m_pos  = 0;
        end else begin
          m_pos = idx + 1;
        end
      end
    end else begin
      m_err = 0;
      if (f) m_hold = 0;
    end
    #1;
    check("image_port",  image_port,  m_img);
    check("data_valid",  DIM'(data_valid),  DIM'(m_hold));
    check("pixel_ready", DIM'(pixel_ready), DIM'(!m_hold));
    check("frame_err",   DIM'(frame_err),   DIM'(m_err));
  endtask

  task automatic rand_pixels(input int n, input bit first_sof);
    for (int i = 0; i < n; i++)
      cycle(1'b1, 8'($urandom), first_sof && i == 0, ($urandom % 4) == 0, 1'b0);
  endtask

  task automatic finish_pulse();
    cycle(1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
    check("finish_ready", DIM'(pixel_ready), DIM'(1));
  endtask

  initial begin
    m_img = '0; m_pos = 0; m_hold = 0; m_err = 0; m_lfsr = 16'hACE1;

    // Reset state
    cycle(1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
    check("rst_image", image_port, '0);
    check("rst_ready", DIM'(pixel_ready), DIM'(1));
    cycle(1'b0, 8'd0, 1'b0, 1'b0, 1'b0);

    // Alternating 200/50 frame
    for (int i = 0; i < DIM; i++) begin
      if (i == DIM - 1) check("alt_not_yet_valid", DIM'(data_valid), DIM'(0));
      cycle(1'b1, (i % 2 == 0) ? 8'd200 : 8'd50, i == 0, 1'b0, 1'b0);
    end
    check("alt_valid", DIM'(data_valid), DIM'(1));
`ifndef INPUT_DITHER_EN
    for (int i = 0; i < DIM; i++) pattern[i] = (i % 2 == 0);
    check("alt_pattern", image_port, pattern);
`endif

    // HOLD ignores pixels
    saved = image_port;
    for (int i = 0; i < 20; i++) cycle(1'b1, 8'd255, 1'b0, 1'b0, 1'b0);
    check("hold_frozen", image_port, saved);
    finish_pulse();

    // Threshold boundary at indices 0..3
    cycle(1'b1, 8'd127, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 8'd128, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 8'd0,   1'b0, 1'b0, 1'b0);
    cycle(1'b1, 8'd255, 1'b0, 1'b0, 1'b0);
`ifndef INPUT_DITHER_EN
    check("threshold_bits", DIM'(image_port[3:0]), DIM'(4'b1010));
`endif
    rand_pixels(DIM - 4, 1'b0);
    check("boundary_frame_valid", DIM'(data_valid), DIM'(1));
    finish_pulse();

    // Mid-frame sof at index 300
    rand_pixels(300, 1'b1);
    cycle(1'b1, 8'($urandom), 1'b1, 1'b0, 1'b0);
    check("sof_err_pulse", DIM'(frame_err), DIM'(1));
    cycle(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
    check("sof_err_clear", DIM'(frame_err), DIM'(0));
    rand_pixels(781, 1'b0);
    check("sof_not_yet_valid", DIM'(data_valid), DIM'(0));
    rand_pixels(1, 1'b0);
    check("sof_frame_valid", DIM'(data_valid), DIM'(1));
    finish_pulse();

    // Reset mid-fill at index 500
    rand_pixels(500, 1'b1);
    cycle(1'b1, 8'd255, 1'b0, 1'b0, 1'b1);
    check("midfill_rst_image", image_port, '0);
    rand_pixels(DIM - 1, 1'b0);
    check("post_rst_not_yet_valid", DIM'(data_valid), DIM'(0));
    rand_pixels(1, 1'b0);
    check("post_rst_valid", DIM'(data_valid), DIM'(1));

    // Random traffic: gaps, stray sof, finish, inputs during HOLD
    for (int i = 0; i < 4000; i++)
      cycle(($urandom % 3) != 0, 8'($urandom), ($urandom % 300) == 0,
            ($urandom % 8) == 0, ($urandom % 3000) == 0);

`ifdef INPUT_DITHER_EN
    cycle(1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < DIM; i++) cycle(1'b1, 8'd0, i == 0, 1'b0, 1'b0);
    check("dither_all0", image_port, '0);
    finish_pulse();
    for (int i = 0; i < DIM; i++) cycle(1'b1, 8'd255, i == 0, 1'b0, 1'b0);
    check("dither_all255", image_port, '1);
    cycle(1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < DIM; i++) cycle(1'b1, 8'd128, i == 0, 1'b0, 1'b0);
    saved = image_port;
    cycle(1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < DIM; i++) cycle(1'b1, 8'd128, i == 0, 1'b0, 1'b0);
    check("dither_repeatable", image_port, saved);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
